// File: rtl/regfile_seq.sv
// regfile_seq: sequencer for MOV/SWAP/ADD/CLR on an external 8-entry register
// file with a temp register R8. It drives the read/write selects and the write
// data, and keeps the carry and zero flags.
module regfile_seq #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ,
    input  logic [1:0]        OP,
    input  logic [2:0]        RA,
    input  logic [2:0]        RB,
    input  logic [2:0]        RD,
    input  logic [DATA_W-1:0] ADATA,
    input  logic [DATA_W-1:0] BDATA,
    output logic [2:0]        SA,
    output logic [2:0]        SB,
    output logic [2:0]        SD,
    output logic              TA,
    output logic              TB,
    output logic              TD,
    output logic              RW,
    output logic [DATA_W-1:0] DDATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              C,
    output logic              Z
);

    localparam logic [1:0] OP_MOV  = 2'b00;
    localparam logic [1:0] OP_SWAP = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR1  = 3'd1,
        S_WR2  = 3'd2,
        S_WR3  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [2:0]        ra_q, ra_d, rb_q, rb_d, rd_q, rd_d;
    logic              c_q, c_d, z_q, z_d;
    logic [2:0]        sa_q, sa_d, sb_q, sb_d, sd_q, sd_d;
    logic              ta_q, ta_d, tb_q, tb_d, td_q, td_d;
    logic              rw_q, rw_d, busy_q, busy_d, done_q, done_d;
    logic [DATA_W:0]   sum_c;
    logic [DATA_W-1:0] ddata_c;

    assign sum_c = (DATA_W+1)'(ADATA) + (DATA_W+1)'(BDATA);

    // Write data: the register file reads combinationally, so data follows the read ports.
    always_comb begin
        ddata_c = '0;
        case (state_q)
            S_WR1: begin
                case (op_q)
                    OP_MOV:  ddata_c = ADATA;
                    OP_SWAP: ddata_c = ADATA;
                    OP_ADD:  ddata_c = sum_c[DATA_W-1:0];
                    OP_CLR:  ddata_c = '0;
                endcase
            end
            S_WR2:   ddata_c = BDATA;
            S_WR3:   ddata_c = ADATA;
            default: ddata_c = '0;
        endcase
    end

    // Next state, latched operation fields and flag updates.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rd_d    = rd_q;
        c_d     = c_q;
        z_d     = z_q;
        case (state_q)
            S_IDLE: begin
                if (REQ) begin
                    state_d = S_WR1;
                    op_d    = OP;
                    ra_d    = RA;
                    rb_d    = RB;
                    rd_d    = RD;
                end
            end
            S_WR1: begin
                state_d = (op_q == OP_SWAP) ? S_WR2 : S_FIN;
                if (op_q != OP_SWAP) begin
                    z_d = (ddata_c == '0);
                end
                if (op_q == OP_ADD) begin
                    c_d = sum_c[DATA_W];
                end
            end
            S_WR2:   state_d = S_WR3;
            S_WR3:   state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control outputs for the upcoming state, so they come straight out of flops.
    always_comb begin
        sa_d   = '0;
        sb_d   = '0;
        sd_d   = '0;
        ta_d   = 1'b0;
        tb_d   = 1'b0;
        td_d   = 1'b0;
        rw_d   = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            S_WR1: begin
                rw_d   = 1'b1;
                busy_d = 1'b1;
                case (op_d)
                    OP_MOV: begin
                        sa_d = ra_d;
                        sd_d = rd_d;
                    end
                    OP_ADD: begin
                        sa_d = ra_d;
                        sb_d = rb_d;
                        sd_d = rd_d;
                    end
                    OP_CLR: begin
                        sd_d = rd_d;
                    end
                    OP_SWAP: begin
                        sa_d = ra_d;
                        td_d = 1'b1;
                    end
                endcase
            end
            S_WR2: begin
                rw_d   = 1'b1;
                busy_d = 1'b1;
                sb_d   = rb_d;
                sd_d   = ra_d;
            end
            S_WR3: begin
                rw_d   = 1'b1;
                busy_d = 1'b1;
                ta_d   = 1'b1;
                sd_d   = rb_d;
            end
            S_FIN: begin
                done_d = 1'b1;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // State, fields, flags and registered controls; reset clears everything at once.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rd_q    <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            sa_q    <= '0;
            sb_q    <= '0;
            sd_q    <= '0;
            ta_q    <= 1'b0;
            tb_q    <= 1'b0;
            td_q    <= 1'b0;
            rw_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rd_q    <= rd_d;
            c_q     <= c_d;
            z_q     <= z_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sd_q    <= sd_d;
            ta_q    <= ta_d;
            tb_q    <= tb_d;
            td_q    <= td_d;
            rw_q    <= rw_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign SA    = sa_q;
    assign SB    = sb_q;
    assign SD    = sd_q;
    assign TA    = ta_q;
    assign TB    = tb_q;
    assign TD    = td_q;
    assign RW    = rw_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign C     = c_q;
    assign Z     = z_q;
    assign DDATA = ddata_c;

endmodule

// File: tb/tb_regfile_seq.sv
// Bench for regfile_seq: a behavioural 9-entry register file (R0..R7 + R8)
// around the sequencer, table-driven single-write ops, then hand sequences.
module tb_regfile_seq;

    logic       CLK;
    logic       RST;
    logic       REQ;
    logic [1:0] OP;
    logic [2:0] RA, RB, RD;
    logic [7:0] ADATA, BDATA;
    logic [2:0] SA, SB, SD;
    logic       TA, TB, TD, RW;
    logic [7:0] DDATA;
    logic       BUSY, DONE, C, Z;

    regfile_seq #(.DATA_W(8)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .OP(OP), .RA(RA), .RB(RB), .RD(RD),
        .ADATA(ADATA), .BDATA(BDATA), .SA(SA), .SB(SB), .SD(SD),
        .TA(TA), .TB(TB), .TD(TD), .RW(RW), .DDATA(DDATA),
        .BUSY(BUSY), .DONE(DONE), .C(C), .Z(Z)
    );

    // Register file model with a bench-side preload port.
    logic [7:0] regs [0:8];
    logic       pl_we;
    logic [3:0] pl_addr;
    logic [7:0] pl_data;

    always @(posedge CLK) begin
        if (pl_we) regs[pl_addr] <= pl_data;
        else if (RW) regs[TD ? 4'd8 : {1'b0, SD}] <= DDATA;
    end
    assign ADATA = TA ? regs[8] : regs[SA];
    assign BDATA = TB ? regs[8] : regs[SB];

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [3:0] a, input logic [7:0] d);
        @(negedge CLK);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(negedge CLK);
        pl_we = 1'b0;
    endtask

    // Issue one request; returns at the negedge inside WR1.
    task automatic issue(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] d);
        @(negedge CLK);
        REQ = 1'b1; OP = op; RA = a; RB = b; RD = d;
        @(negedge CLK);
        REQ = 1'b0;
    endtask

    // Counts cycles since the accepting edge (WR1 = 1) until DONE, bounded.
    task automatic wait_done(output int lat);
        lat = 1;
        while (DONE !== 1'b1 && lat < 10) begin
            @(negedge CLK);
            lat++;
        end
    endtask

    typedef struct {
        logic [1:0] op;
        logic [2:0] ra, rb, rd;
        logic [7:0] a_val, b_val, exp_d;
        logic       exp_c, exp_z;
    } vec_t;

    vec_t vecs [8];
    int   lat;
    int   busy_cnt;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // op, ra, rb, rd, a_val, b_val, exp DDATA, exp C, exp Z (flags carry over)
        vecs[0] = '{2'b00, 3'd3, 3'd3, 3'd6, 8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b0};
        vecs[1] = '{2'b10, 3'd1, 3'd2, 3'd4, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0};
        vecs[2] = '{2'b00, 3'd7, 3'd7, 3'd2, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1};
        vecs[3] = '{2'b10, 3'd1, 3'd2, 3'd4, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vecs[4] = '{2'b10, 3'd1, 3'd2, 3'd5, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0};
        vecs[5] = '{2'b11, 3'd0, 3'd0, 3'd3, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
        vecs[6] = '{2'b10, 3'd6, 3'd6, 3'd6, 8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0};
        vecs[7] = '{2'b11, 3'd1, 3'd1, 3'd0, 8'h44, 8'h44, 8'h00, 1'b1, 1'b1};

        CLK = 1'b0; RST = 1'b1; REQ = 1'b0; OP = 2'b00; RA = '0; RB = '0; RD = '0;
        pl_we = 1'b0; pl_addr = '0; pl_data = '0;
        @(negedge CLK);
        @(negedge CLK);
        chk("reset_ctrl", 32'({RW, BUSY, DONE, C, Z}), 32'h0);
        chk("reset_sel", 32'({SA, SB, SD, TA, TB, TD}), 32'h0);
        chk("reset_ddata", 32'(DDATA), 32'h0);
        RST = 1'b0;

        // Single-write operations from the table.
        for (int i = 0; i < 8; i++) begin
            preload({1'b0, vecs[i].ra}, vecs[i].a_val);
            preload({1'b0, vecs[i].rb}, vecs[i].b_val);
            issue(vecs[i].op, vecs[i].ra, vecs[i].rb, vecs[i].rd);
            chk($sformatf("v%0d_wr1_ctrl", i), 32'({RW, BUSY, TD, SD}), 32'({3'b110, vecs[i].rd}));
            chk($sformatf("v%0d_ddata", i), 32'(DDATA), 32'(vecs[i].exp_d));
            wait_done(lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
            chk($sformatf("v%0d_fin_busy_rw", i), 32'({BUSY, RW}), 32'h0);
            chk($sformatf("v%0d_flags", i), 32'({C, Z}), 32'({vecs[i].exp_c, vecs[i].exp_z}));
            chk($sformatf("v%0d_rd_value", i), 32'(regs[vecs[i].rd]), 32'(vecs[i].exp_d));
        end

        // SWAP R0=0x11 <-> R5=0x22, step by step.
        preload(4'd0, 8'h11);
        preload(4'd5, 8'h22);
        issue(2'b01, 3'd0, 3'd5, 3'd3);
        busy_cnt = 0;
        if (BUSY === 1'b1) busy_cnt++;
        chk("swap_wr1_sel", 32'({RW, SA, TA, SD, TD}), 32'({1'b1, 3'd0, 1'b0, 3'd0, 1'b1}));
        chk("swap_wr1_ddata", 32'(DDATA), 32'h11);
        @(negedge CLK);
        if (BUSY === 1'b1) busy_cnt++;
        chk("swap_wr2_sel", 32'({RW, SB, TB, SD, TD}), 32'({1'b1, 3'd5, 1'b0, 3'd0, 1'b0}));
        chk("swap_wr2_ddata", 32'(DDATA), 32'h22);
        chk("swap_r8", 32'(regs[8]), 32'h11);
        @(negedge CLK);
        if (BUSY === 1'b1) busy_cnt++;
        chk("swap_wr3_sel", 32'({RW, SA, TA, SD, TD}), 32'({1'b1, 3'd0, 1'b1, 3'd5, 1'b0}));
        chk("swap_wr3_ddata", 32'(DDATA), 32'h11);
        chk("swap_r0", 32'(regs[0]), 32'h22);
        @(negedge CLK);
        if (BUSY === 1'b1) busy_cnt++;
        chk("swap_done", 32'({DONE, RW}), 32'b10);
        chk("swap_r5", 32'(regs[5]), 32'h11);
        chk("swap_busy_cycles", 32'(busy_cnt), 32'd3);
        chk("swap_flags_kept", 32'({C, Z}), 32'b11);

        // SWAP with RA == RB leaves the register unchanged, still 4-cycle latency.
        preload(4'd2, 8'h77);
        issue(2'b01, 3'd2, 3'd2, 3'd0);
        wait_done(lat);
        chk("swap_same_latency", 32'(lat), 32'd4);
        chk("swap_same_value", 32'(regs[2]), 32'h77);

        // REQ held high; inputs changed mid-SWAP must be ignored until IDLE.
        preload(4'd1, 8'h33);
        preload(4'd4, 8'h44);
        @(negedge CLK);
        REQ = 1'b1; OP = 2'b01; RA = 3'd1; RB = 3'd4; RD = 3'd0;
        @(negedge CLK);
        OP = 2'b00; RA = 3'd4; RB = 3'd0; RD = 3'd7;
        @(negedge CLK);
        chk("b2b_wr2_ignores_inputs", 32'({SD, SB, DDATA}), 32'({3'd1, 3'd4, 8'h44}));
        @(negedge CLK);
        @(negedge CLK);
        chk("b2b_done", 32'({DONE, BUSY}), 32'b10);
        @(negedge CLK);
        chk("b2b_idle_gap", 32'({DONE, BUSY, RW}), 32'h0);
        @(negedge CLK);
        REQ = 1'b0;
        chk("b2b_next_start", 32'({BUSY, SA, SD, DDATA}), 32'({1'b1, 3'd4, 3'd7, 8'h33}));
        wait_done(lat);
        chk("b2b_mov_latency", 32'(lat), 32'd2);
        chk("b2b_results", 32'({regs[1], regs[4], regs[7]}), 32'({8'h44, 8'h33, 8'h33}));
        chk("b2b_flags", 32'({C, Z}), 32'b10);

        // Reset just after the WR2 write lands: no further writes, flags cleared.
        preload(4'd0, 8'h11);
        preload(4'd5, 8'h22);
        issue(2'b01, 3'd0, 3'd5, 3'd0);
        @(negedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        chk("rst_async_ctrl", 32'({RW, BUSY, DONE, C, Z}), 32'h0);
        chk("rst_async_sel", 32'({SA, SB, SD, TA, TB, TD, DDATA}), 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        chk("rst_regs", 32'({regs[0], regs[5], regs[8]}), 32'({8'h22, 8'h22, 8'h11}));

        // First request after reset is accepted on the first edge.
        issue(2'b00, 3'd5, 3'd5, 3'd1);
        chk("post_rst_accept", 32'({BUSY, RW, SD}), 32'({2'b11, 3'd1}));
        wait_done(lat);
        chk("post_rst_latency", 32'(lat), 32'd2);
        chk("post_rst_value", 32'(regs[1]), 32'h22);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
